// File: rtl/viterbi_traceback.sv
// Viterbi traceback: buffers survivor pointers, picks the best end state, walks back, streams the path.
// Path valid len clocks after the last beat; out_* hold under out_ready low and in_ready drops until EMIT ends.
module viterbi_traceback #(
  parameter int N = 16,
  parameter int I = 3,
  parameter int W = 20,
  localparam int SW = $clog2(I),
  localparam int TW = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [I*SW-1:0] in_psi,
  input  logic            in_last,
  input  logic [I*W-1:0]  in_delta,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_state,
  output logic [TW-1:0]   out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            err_ovf
);

  localparam int AW = $clog2(N);

  typedef enum logic [2:0] {IDLE, LOAD, ARGMAX, TRACE, EMIT} state_t;

  state_t state, state_nxt;

  logic [I*SW-1:0] psi_mem [N];
  logic [SW-1:0]   path_mem [N];

  logic [TW-1:0]   cnt;
  logic [TW-1:0]   len;
  logic [TW-1:0]   len_m1;
  logic [TW-1:0]   cnt_m1;
  logic [SW-1:0]   cur;
  logic [I*W-1:0]  delta;

  logic            accept;
  logic            last_beat;
  logic            ovf_hit;
  logic            emit_hs;
  logic [SW-1:0]   best;
  logic signed [W-1:0] best_val;
  logic [I*SW-1:0] row;
  logic [SW-1:0]   ptr;

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_beat = in_last || (cnt == TW'(N - 1));
  assign ovf_hit   = (state == LOAD) && accept && !in_last && (cnt == TW'(N - 1));
  assign len_m1    = len - TW'(1);
  assign cnt_m1    = cnt - TW'(1);
  assign emit_hs   = out_valid && out_ready;

  // Path memory is not reset, so gate the symbol with out_valid.
  assign out_state = out_valid ? path_mem[out_idx[AW-1:0]] : '0;
  assign out_last  = out_valid && (out_idx == len_m1);

  // Signed argmax; strict greater-than keeps the lowest index on ties.
  always_comb begin
    best     = '0;
    best_val = $signed(delta[W-1:0]);
    for (int j = 1; j < I; j++) begin
      if ($signed(delta[j*W +: W]) > best_val) begin
        best_val = $signed(delta[j*W +: W]);
        best     = SW'(j);
      end
    end
  end

  // Pointers >= I fall through to zero rather than indexing past the row.
  always_comb begin
    row = psi_mem[cnt[AW-1:0]];
    ptr = '0;
    for (int j = 0; j < I; j++) begin
      if (cur == SW'(j)) ptr = row[j*SW +: SW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = in_last ? ARGMAX : LOAD;
      LOAD:   if (accept && last_beat) state_nxt = ARGMAX;
      ARGMAX: state_nxt = (len > TW'(1)) ? TRACE : EMIT;
      TRACE:  if (cnt == TW'(1)) state_nxt = EMIT;
      EMIT:   if (emit_hs && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      len       <= '0;
      cur       <= '0;
      delta     <= '0;
      err_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            err_ovf <= 1'b0;
            cnt     <= TW'(1);
            if (in_last) begin
              delta <= in_delta;
              len   <= TW'(1);
            end
          end
        end
        LOAD: begin
          if (accept) begin
            cnt <= cnt + TW'(1);
            if (last_beat) begin
              delta <= in_delta;
              len   <= cnt + TW'(1);
            end
            if (ovf_hit) err_ovf <= 1'b1;
          end
        end
        ARGMAX: begin
          cur <= best;
          cnt <= len_m1;
          if (len == TW'(1)) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
          end
        end
        TRACE: begin
          cur <= ptr;
          cnt <= cnt_m1;
          if (cnt == TW'(1)) begin
            out_valid <= 1'b1;
            out_idx   <= '0;
          end
        end
        EMIT: begin
          if (emit_hs) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_idx   <= '0;
            end else begin
              out_idx <= out_idx + TW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage arrays carry no reset; stale content is never presented.
  always_ff @(posedge clk) begin
    if (state == LOAD && accept) psi_mem[cnt[AW-1:0]] <= in_psi;
    if (state == ARGMAX)         path_mem[len_m1[AW-1:0]] <= best;
    if (state == TRACE)          path_mem[cnt_m1[AW-1:0]] <= ptr;
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: hand-computed paths, latency, backpressure, overflow, reset.
module tb_viterbi_traceback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_psi = '0;
  logic        in_last = 1'b0;
  logic [59:0] in_delta = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_state;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        err_ovf;

  int compared = 0;
  int mismatched = 0;
  int hs = 0;
  int exp_path [16];

  viterbi_traceback #(.N(16), .I(3), .W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_psi(in_psi),
    .in_last(in_last), .in_delta(in_delta),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && out_valid === 1'b1 && out_ready) hs <= hs + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // State list order is {state0, state1, state2}.
  function automatic logic [5:0] ps(input int a, input int b, input int c);
    return {2'(c), 2'(b), 2'(a)};
  endfunction

  function automatic logic [59:0] dl(input int a, input int b, input int c);
    return {20'(c), 20'(b), 20'(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [5:0] psi, input logic last, input logic [59:0] d);
    in_valid = 1'b1; in_psi = psi; in_last = last; in_delta = d;
    check("in_ready_at_beat", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, cyc, exp_lat);
  endtask

  task automatic recv(input int lo, input int hi, input int len);
    for (int i = lo; i <= hi; i++) begin
      check("out_valid", out_valid, 1);
      check("out_state", out_state, exp_path[i]);
      check("out_idx", out_idx, i);
      check("out_last", out_last, (i == len - 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic four_beat();
    beat(ps(0, 0, 0), 1'b0, dl(0, 0, 0));
    beat(ps(2, 0, 1), 1'b0, dl(0, 0, 0));
    beat(ps(1, 2, 0), 1'b0, dl(0, 0, 0));
    beat(ps(0, 2, 2), 1'b1, dl(-10, -3, -7));
    exp_path[0] = 2; exp_path[1] = 0; exp_path[2] = 2; exp_path[3] = 1;
  endtask

  initial begin
    int hs0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_state", out_state, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err_ovf", err_ovf, 0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Four-beat decode; a stray beat offered while busy must be ignored.
    four_beat();
    check("argmax_busy", busy, 1);
    check("argmax_in_ready", in_ready, 0);
    in_valid = 1'b1; in_last = 1'b1; in_psi = ps(1, 1, 1); in_delta = dl(99, 0, 0);
    wait_valid("lat4", 4);
    in_valid = 1'b0; in_last = 1'b0;
    recv(0, 3, 4);
    check_idle("done4");

    // Single-beat sequence.
    beat(ps(0, 0, 0), 1'b1, dl(0, 7, 7));
    exp_path[0] = 1;
    wait_valid("lat1", 1);
    recv(0, 0, 1);
    check_idle("done1");

    // Backpressure at index 1.
    hs0 = hs;
    four_beat();
    wait_valid("lat4_bp", 4);
    recv(0, 0, 4);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", out_valid, 1);
      check("bp_state", out_state, 0);
      check("bp_idx", out_idx, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    recv(1, 3, 4);
    check("bp_handshakes", hs - hs0, 4);
    check_idle("done_bp");

    // Overflow: 16 beats, no in_last.
    for (int b = 0; b < 16; b++) begin
      beat(ps(1, 2, 0), 1'b0, dl(0, 0, 5));
      if (b == 14) check("ovf_before", err_ovf, 0);
      if (b == 15) check("ovf_after", err_ovf, 1);
    end
    for (int k = 0; k < 16; k++) begin
      case ((15 - k) % 3)
        0: exp_path[k] = 2;
        1: exp_path[k] = 0;
        default: exp_path[k] = 1;
      endcase
    end
    wait_valid("lat16", 16);
    recv(0, 15, 16);
    check_idle("done16");
    check("ovf_sticky", err_ovf, 1);

    // Tie break; also clears the sticky overflow.
    beat(ps(0, 0, 0), 1'b0, dl(0, 0, 0));
    check("ovf_cleared", err_ovf, 0);
    beat(ps(1, 1, 1), 1'b1, dl(-5, -5, -9));
    exp_path[0] = 1; exp_path[1] = 0;
    wait_valid("lat2_tie", 2);
    recv(0, 1, 2);
    check_idle("done_tie");

    // Reset in the middle of EMIT.
    four_beat();
    wait_valid("lat4_rst", 4);
    recv(0, 1, 4);
    check("pre_rst_idx", out_idx, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_idx", out_idx, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    beat(ps(0, 0, 0), 1'b0, dl(0, 0, 0));
    beat(ps(0, 0, 1), 1'b1, dl(1, 2, 3));
    exp_path[0] = 1; exp_path[1] = 2;
    wait_valid("lat2_fresh", 2);
    recv(0, 1, 2);
    check_idle("done_fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
